fp_align_shifter: RTL and testbench

//  Operand-alignment stage of the floating point adder; feeds the mantissa add/complement stage.

---
 rtl/fp_align_pkg.sv | 21 ++
 rtl/fp_exp_compare.sv | 28 ++
 rtl/fp_align_shifter.sv | 110 +++++++++++
 tb/tb_fp_align_shifter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// Shared widths, FSM state type and mantissa-frame helper for the FP adder alignment stage.
package fp_align_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 24;
    localparam int FRAME_W = MAN_W + 3;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Denormals and zeros carry no hidden one; low three bits are G/R/S.
    function automatic logic [FRAME_W-1:0] frame_of(input logic [EXP_W-1:0] exp,
                                                    input logic [MAN_W-2:0] frac);
        return {(exp != '0), frac, 3'b000};
    endfunction

endpackage

// File: rtl/fp_exp_compare.sv
// Effective-exponent comparison: picks the big operand and the saturated alignment shift count.
import fp_align_pkg::*;

module fp_exp_compare (
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    output logic             swap,
    output logic [EXP_W-1:0] exp_big,
    output logic [CNT_W-1:0] cnt
);

    logic [EXP_W-1:0] eff_a;
    logic [EXP_W-1:0] eff_b;
    logic [EXP_W-1:0] exp_small;
    logic [EXP_W-1:0] diff;

    // Denormals share the exponent of the smallest normal.
    assign eff_a     = (exp_a == '0) ? EXP_W'(1) : exp_a;
    assign eff_b     = (exp_b == '0) ? EXP_W'(1) : exp_b;

    assign swap      = (eff_b > eff_a);
    assign exp_big   = swap ? eff_b : eff_a;
    assign exp_small = swap ? eff_a : eff_b;
    assign diff      = exp_big + (~exp_small + EXP_W'(1));

    assign cnt = (diff > EXP_W'(FRAME_W - 1)) ? CNT_W'(FRAME_W - 1) : diff[CNT_W-1:0];

endmodule

// File: rtl/fp_align_shifter.sv
// FP adder alignment stage: shifts the smaller mantissa right one bit per cycle with sticky.
import fp_align_pkg::*;

module fp_align_shifter (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] big_man,
    output logic [FRAME_W-1:0] small_man,
    output logic [EXP_W-1:0]   exp_out,
    output logic               sign_big,
    output logic               sign_small,
    output logic               swap
);

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic               shift_en;

    logic               cmp_swap;
    logic [EXP_W-1:0]   cmp_exp;
    logic [CNT_W-1:0]   cmp_cnt;
    logic [FRAME_W-1:0] frame_a;
    logic [FRAME_W-1:0] frame_b;

    logic [CNT_W-1:0]   cnt_p1;
    logic [FRAME_W-1:0] big_p1;
    logic [FRAME_W-1:0] small_p1;
    logic [EXP_W-1:0]   exp_p1;
    logic               sign_big_p1;
    logic               sign_small_p1;
    logic               swap_p1;

    // One alignment step; bit 0 is the sticky bit and only ever accumulates.
    function automatic logic [FRAME_W-1:0] sticky_shift(input logic [FRAME_W-1:0] s);
        return {1'b0, s[FRAME_W-1:2], s[1] | s[0]};
    endfunction

    fp_exp_compare u_cmp (
        .exp_a   (a[30:23]),
        .exp_b   (b[30:23]),
        .swap    (cmp_swap),
        .exp_big (cmp_exp),
        .cnt     (cmp_cnt)
    );

    assign frame_a   = frame_of(a[30:23], a[22:0]);
    assign frame_b   = frame_of(b[30:23], b[22:0]);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign load      = in_ready && in_valid;
    assign shift_en  = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (cmp_cnt == '0) ? DONE : SHIFT;
            SHIFT:   if (cnt_p1 == CNT_W'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: captured operands, then the iterative alignment of the small frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1        <= '0;
            big_p1        <= '0;
            small_p1      <= '0;
            exp_p1        <= '0;
            sign_big_p1   <= 1'b0;
            sign_small_p1 <= 1'b0;
            swap_p1       <= 1'b0;
        end else if (load) begin
            cnt_p1        <= cmp_cnt;
            big_p1        <= cmp_swap ? frame_b : frame_a;
            small_p1      <= cmp_swap ? frame_a : frame_b;
            exp_p1        <= cmp_exp;
            sign_big_p1   <= cmp_swap ? b[31] : a[31];
            sign_small_p1 <= cmp_swap ? a[31] : b[31];
            swap_p1       <= cmp_swap;
        end else if (shift_en) begin
            cnt_p1        <= cnt_p1 - CNT_W'(1);
            small_p1      <= sticky_shift(small_p1);
        end
    end

    assign big_man    = big_p1;
    assign small_man  = small_p1;
    assign exp_out    = exp_p1;
    assign sign_big   = sign_big_p1;
    assign sign_small = sign_small_p1;
    assign swap       = swap_p1;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Directed and randomized bench for fp_align_shifter against an arithmetic alignment model.
module tb_fp_align_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] big_man;
    logic [26:0] small_man;
    logic [7:0]  exp_out;
    logic        sign_big;
    logic        sign_small;
    logic        swap;

    int total = 0;
    int bad   = 0;

    fp_align_shifter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .big_man    (big_man),
        .small_man  (small_man),
        .exp_out    (exp_out),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .swap       (swap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: alignment by cnt equals a plain right shift, with bit 0 ORing every bit
    // that passed through or stopped at position 0.
    task automatic model(input logic [31:0] pa, input logic [31:0] pb,
                         output logic [26:0] m_big, output logic [26:0] m_small,
                         output logic [7:0] m_exp, output logic m_swap,
                         output logic m_sb, output logic m_ss, output int m_lat);
        int ea, eb, diff, cnt;
        longint fa, fb, fs, shifted, mask;
        ea = (pa[30:23] == 0) ? 1 : int'(pa[30:23]);
        eb = (pb[30:23] == 0) ? 1 : int'(pb[30:23]);
        fa = ((pa[30:23] != 0) ? 64'd1 << 26 : 64'd0) + (longint'(pa[22:0]) * 8);
        fb = ((pb[30:23] != 0) ? 64'd1 << 26 : 64'd0) + (longint'(pb[22:0]) * 8);
        m_swap = (eb > ea);
        diff   = m_swap ? eb - ea : ea - eb;
        cnt    = (diff > 26) ? 26 : diff;
        m_exp  = 8'(m_swap ? eb : ea);
        m_big  = 27'(m_swap ? fb : fa);
        fs     = m_swap ? fa : fb;
        mask   = (64'd2 << cnt) - 1;
        shifted = fs >> cnt;
        if ((fs & mask) != 0) shifted = shifted | 64'd1;
        m_small = 27'(shifted);
        m_sb   = m_swap ? pb[31] : pa[31];
        m_ss   = m_swap ? pa[31] : pb[31];
        m_lat  = cnt + 1;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] pa, input logic [31:0] pb,
                                input int lat);
        logic [26:0] m_big, m_small;
        logic [7:0]  m_exp;
        logic        m_swap, m_sb, m_ss;
        int          m_lat;
        model(pa, pb, m_big, m_small, m_exp, m_swap, m_sb, m_ss, m_lat);
        chk({tag, "_lat"},   64'(lat), 64'(m_lat));
        chk({tag, "_vld"},   64'(out_valid), 64'd1);
        chk({tag, "_big"},   64'(big_man), 64'(m_big));
        chk({tag, "_small"}, 64'(small_man), 64'(m_small));
        chk({tag, "_exp"},   64'(exp_out), 64'(m_exp));
        chk({tag, "_swap"},  64'(swap), 64'(m_swap));
        chk({tag, "_sb"},    64'(sign_big), 64'(m_sb));
        chk({tag, "_ss"},    64'(sign_small), 64'(m_ss));
        chk({tag, "_rdy"},   64'(in_ready), 64'd0);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_pair(input string tag, input logic [31:0] pa, input logic [31:0] pb);
        int lat;
        @(negedge clk);
        a = pa;
        b = pb;
        in_valid = 1'b1;
        chk({tag, "_accept_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        check_result(tag, pa, pb, lat);
        drain(tag);
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] ra, rb;
        logic [26:0] h_big, h_small;
        logic [7:0]  h_exp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy",   64'(in_ready), 64'd1);
        chk("rst_vld",   64'(out_valid), 64'd0);
        chk("rst_big",   64'(big_man), 64'd0);
        chk("rst_small", 64'(small_man), 64'd0);
        chk("rst_exp",   64'(exp_out), 64'd0);
        chk("rst_swap",  64'(swap), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived constants.
        run_pair("c1", 32'h40400000, 32'h3F800000);
        chk("c1_big_const",   64'(big_man), 64'h6000000);
        chk("c1_small_const", 64'(small_man), 64'h2000000);
        chk("c1_exp_const",   64'(exp_out), 64'h80);
        run_pair("c2", 32'h3F800000, 32'hC0400000);
        chk("c2_swap_const",  64'(swap), 64'd1);
        chk("c2_sb_const",    64'(sign_big), 64'd1);
        chk("c2_small_const", 64'(small_man), 64'h2000000);
        run_pair("c3", 32'h4B800000, 32'h3F800000);
        chk("c3_small_const", 64'(small_man), 64'h0000004);
        run_pair("c4", 32'h64000000, 32'h3F800001);
        chk("c4_small_const", 64'(small_man), 64'h0000001);
        run_pair("tie", 32'h3FC00000, 32'hBF800000);
        run_pair("zero", 32'h00000000, 32'h3F800000);
        run_pair("denorm", 32'h00400001, 32'h00000003);
        run_pair("inf", 32'h7F800000, 32'h7FC00001);

        // Backpressure: hold DONE while a second pair waits on in_valid.
        @(negedge clk);
        a = 32'h40400000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h41200000;
        b = 32'h40000000;
        wait_done(lat);
        chk("bp_lat", 64'(lat), 64'd2);
        h_big   = big_man;
        h_small = small_man;
        h_exp   = exp_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_vld_hold",   64'(out_valid), 64'd1);
            chk("bp_rdy_low",    64'(in_ready), 64'd0);
            chk("bp_big_hold",   64'(big_man), 64'h6000000);
            chk("bp_small_hold", 64'(small_man), 64'h2000000);
            chk("bp_exp_hold",   64'(exp_out), 64'h80);
        end
        chk("bp_big_stable",   64'(big_man), 64'(h_big));
        chk("bp_small_stable", 64'(small_man), 64'(h_small));
        chk("bp_exp_stable",   64'(exp_out), 64'(h_exp));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_vld_drop", 64'(out_valid), 64'd0);
        chk("bp_rdy_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        check_result("bp2", 32'h41200000, 32'h40000000, lat);
        drain("bp2");

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        a = 32'h4B800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_vld",   64'(out_valid), 64'd0);
        chk("mr_big",   64'(big_man), 64'd0);
        chk("mr_small", 64'(small_man), 64'd0);
        chk("mr_exp",   64'(exp_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_rdy", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("mr_no_result", 64'(seen), 64'd0);
        chk("mr_rdy_after", 64'(in_ready), 64'd1);

        // Randomized pairs, half with nearby exponents to exercise short shifts.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) rb[30:23] = ra[30:23] ^ 8'($urandom_range(0, 31));
            if (i % 6 == 0) ra[30:23] = 8'd0;
            if (i % 7 == 3) rb[30:0] = 31'd0;
            run_pair("rnd", ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
